// File: rtl/uart_irq_scheduler.sv
// uart_irq_scheduler: 16550-style interrupt pending tracking and IIR/irq resolution.
// Optional feature macro MODEM_IRQ_EN enables the modem-status interrupt source.
module uart_irq_scheduler #(
  parameter int FRAME_BITS    = 10,
  parameter int OVERSAMPLE    = 16,
  parameter int TIMEOUT_CHARS = 4,
  parameter int FIFO_AW       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ier,
  input  logic [1:0]       rx_trig,
  input  logic [FIFO_AW:0] rx_count,
  input  logic             rx_push,
  input  logic             rx_pop,
  input  logic             tx_empty,
  input  logic             tx_push,
  input  logic             lsr_err,
  input  logic             lsr_rd,
  input  logic             msr_delta,
  input  logic             msr_rd,
  input  logic             iir_rd,
  input  logic             baud_tick,
  output logic             irq,
  output logic [3:0]       iir
);

  localparam int LIMIT = TIMEOUT_CHARS * FRAME_BITS * OVERSAMPLE;
  localparam int TW    = $clog2(LIMIT + 1);
  localparam int RW    = FIFO_AW + 1;

  localparam logic [3:0] IIR_RLS  = 4'b0110;
  localparam logic [3:0] IIR_RDA  = 4'b0100;
  localparam logic [3:0] IIR_CTI  = 4'b1100;
  localparam logic [3:0] IIR_THRE = 4'b0010;
  localparam logic [3:0] IIR_MS   = 4'b0000;
  localparam logic [3:0] IIR_NONE = 4'b0001;

  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] trig;
  logic [3:0]    iir_q, iir_d;
  logic          irq_q;
  logic          rls_q, rls_d;
  logic          cti_q, cti_d;
  logic          thre_q, thre_d;
  logic          ms_d, ms_en;
  logic          txe_q, ier1_q;
  logic          rda, rx_clr;
  logic          thre_set, thre_clr;

  always_comb begin
    trig = RW'(1);
    unique case (rx_trig)
      2'd0:    trig = RW'(1);
      2'd1:    trig = RW'(4);
      2'd2:    trig = RW'(8);
      default: trig = RW'(14);
    endcase
  end

  assign rda    = rx_count >= trig;
  assign rx_clr = rx_push | rx_pop | (rx_count == '0);

  always_comb begin
    tmo_d = tmo_q;
    if (rx_clr)
      tmo_d = '0;
    else if (baud_tick && (tmo_q != TW'(LIMIT)))
      tmo_d = tmo_q + TW'(1);
  end

  assign cti_d = ~rx_clr & (cti_q | (tmo_d == TW'(LIMIT)));

  assign rls_d = lsr_err | (rls_q & ~lsr_rd);

  // THRE re-arms on an empty edge or on ETBEI being enabled while empty
  assign thre_set = tx_empty & (~txe_q | (ier[1] & ~ier1_q));
  assign thre_clr = tx_push | (iir_rd & (iir_q == IIR_THRE));
  assign thre_d   = thre_set | (thre_q & ~thre_clr);

`ifdef MODEM_IRQ_EN
  logic ms_q;

  assign ms_d  = msr_delta | (ms_q & ~msr_rd);
  assign ms_en = ier[3];

  always_ff @(posedge clk) begin
    if (rst) ms_q <= 1'b0;
    else     ms_q <= ms_d;
  end
`else
  logic unused_ms;

  assign unused_ms = ^{msr_delta, msr_rd, ier[3]};
  assign ms_d      = 1'b0;
  assign ms_en     = 1'b0;
`endif

  always_comb begin
    iir_d = IIR_NONE;
    if (rls_d & ier[2])
      iir_d = IIR_RLS;
    else if (rda & ier[0])
      iir_d = IIR_RDA;
    else if (cti_d & ier[0])
      iir_d = IIR_CTI;
    else if (thre_d & ier[1])
      iir_d = IIR_THRE;
    else if (ms_d & ms_en)
      iir_d = IIR_MS;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q  <= '0;
      rls_q  <= 1'b0;
      cti_q  <= 1'b0;
      thre_q <= 1'b0;
      iir_q  <= IIR_NONE;
      irq_q  <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      rls_q  <= rls_d;
      cti_q  <= cti_d;
      thre_q <= thre_d;
      iir_q  <= iir_d;
      irq_q  <= ~iir_d[0];
    end
    txe_q  <= tx_empty;
    ier1_q <= ier[1];
  end

  assign iir = iir_q;
  assign irq = irq_q;

endmodule
